// File: rtl/dmul_bi_acc_if.sv
// ---------------------------------------------------------------------------
// dmul_bi_acc_if
// Bundles the operand, control, sequence and result signals of the
// stochastic multiplier-accumulator into one interface.
//   master : driver side (operands, loads, mode, start, sequence values in;
//            sequence advance, product bit, busy, valid, count out)
//   slave  : the dmul_bi_acc block itself
// Ports carried:
//   iA, iB               operand magnitudes
//   loadA, loadB         operand buffer load enables
//   mode                 0 = unipolar (AND), 1 = bipolar (XNOR)
//   start                single-cycle run request
//   sobolSeqA, sobolSeqB external low-discrepancy sequence values
//   oSeqEn               advance request to the sequence generators
//   oC                   product bit
//   oBusy                high while a run is in progress
//   oValid               one-cycle result strobe
//   oCnt                 ones counted in oC over the last completed run
// ---------------------------------------------------------------------------
interface dmul_bi_acc_if #(
   parameter int WIDTH    = 8,
   parameter int LEN_LOG2 = 8
);
   logic [WIDTH-1:0]  iA;
   logic [WIDTH-1:0]  iB;
   logic              loadA;
   logic              loadB;
   logic              mode;
   logic              start;
   logic [WIDTH-1:0]  sobolSeqA;
   logic [WIDTH-1:0]  sobolSeqB;
   logic              oSeqEn;
   logic              oC;
   logic              oBusy;
   logic              oValid;
   logic [LEN_LOG2:0] oCnt;

   modport master (
      output iA, iB, loadA, loadB, mode, start, sobolSeqA, sobolSeqB,
      input  oSeqEn, oC, oBusy, oValid, oCnt
   );

   modport slave (
      input  iA, iB, loadA, loadB, mode, start, sobolSeqA, sobolSeqB,
      output oSeqEn, oC, oBusy, oValid, oCnt
   );
endinterface

// File: rtl/dmul_bi_acc.sv
// ---------------------------------------------------------------------------
// dmul_bi_acc
// Stochastic-computing multiplier with a run-length accumulator. Each
// operand is turned into a bit stream by comparing it against an external
// low-discrepancy sequence; the two stream bits are multiplied with AND
// (unipolar) or XNOR (bipolar) and the ones are counted over a run of
// 2^LEN_LOG2 cycles.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous, active-low reset
//   acc_if  dmul_bi_acc_if.slave bundle (operands, control, sequences in;
//           oSeqEn, oC, oBusy, oValid, oCnt out)
// ---------------------------------------------------------------------------
module dmul_bi_acc #(
   parameter int WIDTH    = 8,
   parameter int LEN_LOG2 = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   dmul_bi_acc_if.slave acc_if
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [LEN_LOG2-1:0] LAST_CYCLE = {LEN_LOG2{1'b1}};

   logic [1:0]          state_q, state_d;
   logic [WIDTH-1:0]    aBuf_q, aBuf_d;
   logic [WIDTH-1:0]    bBuf_q, bBuf_d;
   logic                modeR_q, modeR_d;
   logic [LEN_LOG2-1:0] cycle_q, cycle_d;
   logic [LEN_LOG2:0]   acc_q, acc_d;
   logic [LEN_LOG2:0]   cnt_q, cnt_d;

   logic                bitA;
   logic                bitB;
   logic                prodBit;
   logic [LEN_LOG2:0]   accInc;

   // Stream bits come from a strict compare, so a zero operand never
   // produces a one. The product is formed in every state, not only in RUN,
   // using the mode latched at the last accepted start.
   assign bitA    = (aBuf_q > acc_if.sobolSeqA);
   assign bitB    = (bBuf_q > acc_if.sobolSeqB);
   assign prodBit = modeR_q ? ~(bitA ^ bitB) : (bitA & bitB);
   assign accInc  = acc_q + {{LEN_LOG2{1'b0}}, prodBit};

   // Status outputs are decoded straight from the state register so that
   // reset forces them low immediately.
   assign acc_if.oC     = prodBit;
   assign acc_if.oSeqEn = (state_q == RUN);
   assign acc_if.oBusy  = (state_q == RUN);
   assign acc_if.oValid = (state_q == DONE);
   assign acc_if.oCnt   = cnt_q;

   // Next-state logic. Operand loads and start are honoured only outside
   // RUN; DONE behaves like IDLE for loads so a back-to-back run can pick
   // up fresh operands on the same edge that restarts it. The final RUN
   // cycle's product bit is folded into the published count.
   always_comb begin
      state_d = state_q;
      aBuf_d  = aBuf_q;
      bBuf_d  = bBuf_q;
      modeR_d = modeR_q;
      cycle_d = cycle_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (acc_if.loadA) begin
               aBuf_d = acc_if.iA;
            end
            if (acc_if.loadB) begin
               bBuf_d = acc_if.iB;
            end
            if (acc_if.start) begin
               state_d = RUN;
               modeR_d = acc_if.mode;
               cycle_d = '0;
               acc_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d   = accInc;
            cycle_d = cycle_q + 1'b1;
            if (cycle_q == LAST_CYCLE) begin
               state_d = DONE;
               cnt_d   = accInc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset clears everything, including the held result,
   // so an aborted run leaves no trace and produces no strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aBuf_q  <= '0;
         bBuf_q  <= '0;
         modeR_q <= 1'b0;
         cycle_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         aBuf_q  <= aBuf_d;
         bBuf_q  <= bBuf_d;
         modeR_q <= modeR_d;
         cycle_q <= cycle_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dmul_bi_acc.sv
// ---------------------------------------------------------------------------
// tb_dmul_bi_acc
// Self-checking bench for dmul_bi_acc (WIDTH=8, LEN_LOG2=8). A counting
// sequence c=0..255 stands in for the Sobol generators and advances on
// oSeqEn. A run-level model predicts each run's count from closed-form
// arithmetic and the per-cycle product bit from the operand rule; a
// negedge process compares every output on every cycle, and directed
// scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_dmul_bi_acc;

   localparam int WIDTH    = 8;
   localparam int LEN_LOG2 = 8;
   localparam int RUN_LEN  = 2 ** LEN_LOG2;

   logic clk;
   logic rst_n;
   logic checkEn;
   logic [WIDTH-1:0] seqC;

   int checks;
   int errors;

   logic [WIDTH-1:0] mA;
   logic [WIDTH-1:0] mB;
   logic             mMode;
   logic             mBusy;
   logic             mValid;
   int               mLeft;
   int               mExpect;
   int               mCnt;

   dmul_bi_acc_if #(.WIDTH(WIDTH), .LEN_LOG2(LEN_LOG2)) bus ();

   dmul_bi_acc #(.WIDTH(WIDTH), .LEN_LOG2(LEN_LOG2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc_if (bus)
   );

   assign bus.sobolSeqA = seqC;
   assign bus.sobolSeqB = seqC;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in sequence generator: steps once per cycle the block requests it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seqC <= '0;
      end else if (bus.oSeqEn) begin
         seqC <= seqC + 1'b1;
      end
   end

   // Count of c in 0..RUN_LEN-1 for which the product bit is one.
   // Unipolar: both c<a and c<b, i.e. min(a,b). Bipolar: the two stream
   // bits agree everywhere except for c between min and max.
   function automatic int expectCount(input int a, input int b, input logic m);
      int lo;
      int hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      return m ? (RUN_LEN - (hi - lo)) : lo;
   endfunction

   function automatic logic productBit(input int a, input int b, input logic m, input int c);
      logic sa;
      logic sb;
      sa = (a > c);
      sb = (b > c);
      return m ? (sa == sb) : (sa && sb);
   endfunction

   // Run-level model: a start outside a run books a result computed from
   // the operands in force for that run, then the run simply lasts RUN_LEN
   // cycles before the result is published for one strobe cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mA      <= '0;
         mB      <= '0;
         mMode   <= 1'b0;
         mBusy   <= 1'b0;
         mValid  <= 1'b0;
         mLeft   <= 0;
         mExpect <= 0;
         mCnt    <= 0;
      end else if (mBusy) begin
         mLeft <= mLeft - 1;
         if (mLeft == 1) begin
            mBusy  <= 1'b0;
            mValid <= 1'b1;
            mCnt   <= mExpect;
         end
      end else begin
         mValid <= 1'b0;
         if (bus.loadA) mA <= bus.iA;
         if (bus.loadB) mB <= bus.iB;
         if (bus.start) begin
            mBusy   <= 1'b1;
            mLeft   <= RUN_LEN;
            mMode   <= bus.mode;
            mExpect <= expectCount(bus.loadA ? int'(bus.iA) : int'(mA),
                                   bus.loadB ? int'(bus.iB) : int'(mB), bus.mode);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("oBusy",  int'(bus.oBusy),  int'(mBusy));
         checkOutput("oSeqEn", int'(bus.oSeqEn), int'(mBusy));
         checkOutput("oValid", int'(bus.oValid), int'(mValid));
         checkOutput("oCnt",   int'(bus.oCnt),   mCnt);
         checkOutput("oC",     int'(bus.oC),
                     int'(productBit(int'(mA), int'(mB), mMode, int'(seqC))));
      end
   end

   // Load both operands, then raise start for one cycle (cleared by waitValid).
   task automatic applyStimulus(input int a, input int b, input logic m);
      @(negedge clk);
      bus.iA    = a[WIDTH-1:0];
      bus.iB    = b[WIDTH-1:0];
      bus.loadA = 1'b1;
      bus.loadB = 1'b1;
      bus.mode  = m;
      @(negedge clk);
      bus.loadA = 1'b0;
      bus.loadB = 1'b0;
      bus.start = 1'b1;
   endtask

   // Counts cycles from the start edge to the oValid cycle. At cycle
   // pulseAt it tries to disturb the run with a load, a start and a mode
   // flip, all of which must be ignored.
   task automatic waitValid(input int pulseAt, output int edges, output int firstBusy);
      edges     = 0;
      firstBusy = 0;
      do begin
         @(negedge clk);
         edges++;
         if (edges == 1) begin
            firstBusy = int'(bus.oBusy);
            bus.start = 1'b0;
            bus.loadA = 1'b0;
            bus.loadB = 1'b0;
         end
         if (edges == pulseAt) begin
            bus.iA    = 8'd7;
            bus.loadA = 1'b1;
            bus.start = 1'b1;
            bus.mode  = ~bus.mode;
         end
         if (edges == pulseAt + 1) begin
            bus.loadA = 1'b0;
            bus.start = 1'b0;
         end
      end while (!bus.oValid && edges < 400);
      if (!bus.oValid) begin
         checkOutput("validTimeout", 0, 1);
      end
   endtask

   initial begin
      int e;
      int fb;
      checks    = 0;
      errors    = 0;
      checkEn   = 1'b0;
      rst_n     = 1'b0;
      bus.iA    = '0;
      bus.iB    = '0;
      bus.loadA = 1'b0;
      bus.loadB = 1'b0;
      bus.mode  = 1'b0;
      bus.start = 1'b0;

      @(posedge clk);
      #1 checkEn = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("resetBusy",  int'(bus.oBusy),  0);
      checkOutput("resetValid", int'(bus.oValid), 0);
      checkOutput("resetCnt",   int'(bus.oCnt),   0);
      checkOutput("resetSeqEn", int'(bus.oSeqEn), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idleAfterReset", int'(bus.oBusy), 0);

      $display("[TB] unipolar A=128 B=255");
      applyStimulus(128, 255, 1'b0);
      waitValid(0, e, fb);
      checkOutput("uniLatency", e, 257);
      checkOutput("uniCnt", int'(bus.oCnt), 128);

      $display("[TB] bipolar A=128 B=128 with mode flip mid-run");
      applyStimulus(128, 128, 1'b1);
      waitValid(60, e, fb);
      checkOutput("biSameCnt", int'(bus.oCnt), 256);

      $display("[TB] bipolar A=0 B=255");
      applyStimulus(0, 255, 1'b1);
      waitValid(0, e, fb);
      checkOutput("biExtremeCnt", int'(bus.oCnt), 1);

      $display("[TB] back-to-back runs");
      applyStimulus(128, 255, 1'b0);
      waitValid(50, e, fb);
      checkOutput("b2bFirstCnt", int'(bus.oCnt), 128);
      bus.iA    = 8'd64;
      bus.loadA = 1'b1;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      waitValid(0, e, fb);
      checkOutput("b2bBusyNext", fb, 1);
      checkOutput("b2bLatency", e, 257);
      checkOutput("b2bSecondCnt", int'(bus.oCnt), 64);

      $display("[TB] reset mid-run");
      applyStimulus(128, 128, 1'b1);
      bus.start = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      checkOutput("preResetBusy", int'(bus.oBusy), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncBusy",  int'(bus.oBusy),  0);
      checkOutput("asyncCnt",   int'(bus.oCnt),   0);
      checkOutput("asyncC",     int'(bus.oC),     0);
      checkOutput("asyncSeqEn", int'(bus.oSeqEn), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("noValidAfterAbort", int'(bus.oValid), 0);
      end
      applyStimulus(255, 255, 1'b0);
      waitValid(0, e, fb);
      checkOutput("postResetLatency", e, 257);
      checkOutput("postResetCnt", int'(bus.oCnt), 255);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
